// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-memory sequencer for the RV32I core.
// Boot-loads program words into a word-addressed memory, then fetches
// sequentially from RESET_PC and hands instruction/PC pairs to decode
// over valid/ready. Handles redirects, halts on EBREAK and faults on
// misaligned or out-of-range PCs.
// Optional feature macro: BOOT_LOAD_EN (when undefined the LOAD phase is
// removed and reset enters RUN with memory preloaded externally).
module imem_fetch_ctrl #(
  parameter int unsigned DEPTH    = 64,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_valid,
  output logic        ld_ready,
  input  logic [31:0] ld_data,
  input  logic        ld_last,
  output logic        mem_we,
  output logic [31:0] mem_wadd,
  output logic [31:0] mem_wdata,
  output logic [31:0] im_add,
  input  logic [31:0] instruction,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        halted,
  output logic        fault
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

`ifdef BOOT_LOAD_EN
  localparam logic [1:0] ST_RESET = ST_LOAD;
`else
  localparam logic [1:0] ST_RESET = ST_RUN;
`endif

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] pc_out_q, pc_out_d;
  logic        fault_q, fault_d;
  logic        load_en;

`ifdef BOOT_LOAD_EN
  logic [AW-1:0] ld_cnt_q, ld_cnt_d;
`else
  logic unused_ld;
  assign unused_ld = ^{ld_valid, ld_data, ld_last};
`endif

  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_out_q;
  assign pc_out      = pc_out_q;
  assign fault       = fault_q;
  assign halted      = (state_q == ST_HALT);
  assign load_en     = !instr_valid_q || instr_ready;

  // Next-state and output decode for load, fetch and halt phases.
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    instr_valid_d = instr_valid_q;
    instr_out_d   = instr_out_q;
    pc_out_d      = pc_out_q;
    fault_d       = fault_q;
`ifdef BOOT_LOAD_EN
    ld_cnt_d      = ld_cnt_q;
`endif
    ld_ready      = 1'b0;
    mem_we        = 1'b0;
    mem_wadd      = '0;
    mem_wdata     = '0;
    im_add        = pc_q;

    case (state_q)
`ifdef BOOT_LOAD_EN
      ST_LOAD: begin
        ld_ready  = 1'b1;
        mem_we    = ld_valid;
        mem_wadd  = 32'(ld_cnt_q) << 2;
        mem_wdata = ld_data;
        im_add    = '0;
        if (ld_valid) begin
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_last || (ld_cnt_q == AW'(DEPTH - 1))) begin
            state_d = ST_RUN;
          end
        end
      end
`endif
      ST_RUN: begin
        if (redirect_valid) begin
          instr_valid_d = 1'b0;
          pc_d          = redirect_pc;
          if (redirect_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            state_d = ST_HALT;
          end
        end else if (load_en) begin
          if (pc_q[31:2] >= 30'(DEPTH)) begin
            fault_d       = 1'b1;
            state_d       = ST_HALT;
            instr_valid_d = 1'b0;
          end else begin
            instr_out_d   = instruction;
            pc_out_d      = pc_q;
            instr_valid_d = 1'b1;
            if (instruction == EBREAK) begin
              state_d = ST_HALT;
            end else begin
              pc_d = pc_q + 32'd4;
            end
          end
        end
      end
      ST_HALT: begin
        if (instr_valid_q && instr_ready) begin
          instr_valid_d = 1'b0;
        end
      end
      default: begin
        state_d = ST_RESET;
      end
    endcase
  end

  // Register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RESET;
      pc_q          <= RESET_PC;
      instr_valid_q <= 1'b0;
      instr_out_q   <= '0;
      pc_out_q      <= '0;
      fault_q       <= 1'b0;
`ifdef BOOT_LOAD_EN
      ld_cnt_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_valid_q <= instr_valid_d;
      instr_out_q   <= instr_out_d;
      pc_out_q      <= pc_out_d;
      fault_q       <= fault_d;
`ifdef BOOT_LOAD_EN
      ld_cnt_q      <= ld_cnt_d;
`endif
    end
  end

endmodule
